// File: rtl/etx_emesh_arbiter.sv
// rtl/etx_emesh_arbiter.sv - two-requester eMesh transmit arbiter with registered output stage
// Optional: ETX_ARB_FIXED_PRIO_EN selects strict A-over-B priority instead of round-robin burst hold.
module etx_emesh_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic        txo_lclk,
    input  logic        reset,
    input  logic        a_emesh_access,
    input  logic        a_emesh_write,
    input  logic [1:0]  a_emesh_datamode,
    input  logic [3:0]  a_emesh_ctrlmode,
    input  logic [31:0] a_emesh_dstaddr,
    input  logic [31:0] a_emesh_srcaddr,
    input  logic [31:0] a_emesh_data,
    output logic        a_emesh_wait,
    input  logic        b_emesh_access,
    input  logic        b_emesh_write,
    input  logic [1:0]  b_emesh_datamode,
    input  logic [3:0]  b_emesh_ctrlmode,
    input  logic [31:0] b_emesh_dstaddr,
    input  logic [31:0] b_emesh_srcaddr,
    input  logic [31:0] b_emesh_data,
    output logic        b_emesh_wait,
    output logic        txo_emesh_access,
    output logic        txo_emesh_write,
    output logic [1:0]  txo_emesh_datamode,
    output logic [3:0]  txo_emesh_ctrlmode,
    output logic [31:0] txo_emesh_dstaddr,
    output logic [31:0] txo_emesh_srcaddr,
    output logic [31:0] txo_emesh_data,
    input  logic        txo_emesh_wait,
    output logic        grant_a,
    output logic        grant_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state;
    logic   load_en;
    logic   sel_a;
    logic   sel_b;

    // Output stage can take a new transaction when empty or draining this cycle.
    assign load_en = ~(txo_emesh_access & txo_emesh_wait);

`ifdef ETX_ARB_FIXED_PRIO_EN
    assign sel_a = a_emesh_access;
    assign sel_b = b_emesh_access & ~a_emesh_access;
`else
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic             rr_b;
    logic             under_limit;
    logic             keep_a;
    logic             keep_b;

    assign under_limit = burst_cnt < MAX_CNT;
    assign keep_a = (state == OWN_A) & a_emesh_access & (under_limit | ~b_emesh_access);
    assign keep_b = (state == OWN_B) & b_emesh_access & (under_limit | ~a_emesh_access);

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (keep_a) begin
            sel_a = 1'b1;
        end else if (keep_b) begin
            sel_b = 1'b1;
        end else if (a_emesh_access & b_emesh_access) begin
            sel_a = ~rr_b;
            sel_b = rr_b;
        end else begin
            sel_a = a_emesh_access;
            sel_b = b_emesh_access;
        end
    end

    // A full burst with an idle peer wraps the count so the owner keeps streaming.
    always_ff @(posedge txo_lclk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
            rr_b      <= 1'b0;
        end else if (load_en) begin
            if (sel_a | sel_b) begin
                if ((sel_a & (state == OWN_A)) | (sel_b & (state == OWN_B))) begin
                    burst_cnt <= (burst_cnt >= MAX_CNT) ? CNT_W'(1) : burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= CNT_W'(1);
                    rr_b      <= sel_a;
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end
`endif

    assign a_emesh_wait = ~load_en | ~sel_a;
    assign b_emesh_wait = ~load_en | ~sel_b;

    always_ff @(posedge txo_lclk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
        end else if (load_en) begin
            if (sel_a) begin
                state   <= OWN_A;
                grant_a <= 1'b1;
                grant_b <= 1'b0;
            end else if (sel_b) begin
                state   <= OWN_B;
                grant_a <= 1'b0;
                grant_b <= 1'b1;
            end else begin
                state   <= IDLE;
                grant_a <= 1'b0;
                grant_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge txo_lclk or posedge reset) begin
        if (reset) begin
            txo_emesh_access   <= 1'b0;
            txo_emesh_write    <= 1'b0;
            txo_emesh_datamode <= 2'd0;
            txo_emesh_ctrlmode <= 4'd0;
            txo_emesh_dstaddr  <= 32'd0;
            txo_emesh_srcaddr  <= 32'd0;
            txo_emesh_data     <= 32'd0;
        end else if (load_en) begin
            if (sel_a | sel_b) begin
                txo_emesh_access   <= 1'b1;
                txo_emesh_write    <= sel_a ? a_emesh_write    : b_emesh_write;
                txo_emesh_datamode <= sel_a ? a_emesh_datamode : b_emesh_datamode;
                txo_emesh_ctrlmode <= sel_a ? a_emesh_ctrlmode : b_emesh_ctrlmode;
                txo_emesh_dstaddr  <= sel_a ? a_emesh_dstaddr  : b_emesh_dstaddr;
                txo_emesh_srcaddr  <= sel_a ? a_emesh_srcaddr  : b_emesh_srcaddr;
                txo_emesh_data     <= sel_a ? a_emesh_data     : b_emesh_data;
            end else begin
                txo_emesh_access   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_etx_emesh_arbiter.sv
// tb/tb_etx_emesh_arbiter.sv - randomized and directed bench for etx_emesh_arbiter against a behavioural model
module tb_etx_emesh_arbiter;

    localparam int MAXB = 4;

    logic        txo_lclk = 1'b0;
    logic        reset = 1'b1;
    logic        a_emesh_access = 1'b0, a_emesh_write = 1'b0;
    logic [1:0]  a_emesh_datamode = '0;
    logic [3:0]  a_emesh_ctrlmode = '0;
    logic [31:0] a_emesh_dstaddr = '0, a_emesh_srcaddr = '0, a_emesh_data = '0;
    logic        a_emesh_wait;
    logic        b_emesh_access = 1'b0, b_emesh_write = 1'b0;
    logic [1:0]  b_emesh_datamode = '0;
    logic [3:0]  b_emesh_ctrlmode = '0;
    logic [31:0] b_emesh_dstaddr = '0, b_emesh_srcaddr = '0, b_emesh_data = '0;
    logic        b_emesh_wait;
    logic        txo_emesh_access, txo_emesh_write;
    logic [1:0]  txo_emesh_datamode;
    logic [3:0]  txo_emesh_ctrlmode;
    logic [31:0] txo_emesh_dstaddr, txo_emesh_srcaddr, txo_emesh_data;
    logic        txo_emesh_wait = 1'b0;
    logic        grant_a, grant_b;

    etx_emesh_arbiter #(.MAX_BURST(MAXB), .CNT_W(5)) dut (
        .txo_lclk(txo_lclk), .reset(reset),
        .a_emesh_access(a_emesh_access), .a_emesh_write(a_emesh_write),
        .a_emesh_datamode(a_emesh_datamode), .a_emesh_ctrlmode(a_emesh_ctrlmode),
        .a_emesh_dstaddr(a_emesh_dstaddr), .a_emesh_srcaddr(a_emesh_srcaddr),
        .a_emesh_data(a_emesh_data), .a_emesh_wait(a_emesh_wait),
        .b_emesh_access(b_emesh_access), .b_emesh_write(b_emesh_write),
        .b_emesh_datamode(b_emesh_datamode), .b_emesh_ctrlmode(b_emesh_ctrlmode),
        .b_emesh_dstaddr(b_emesh_dstaddr), .b_emesh_srcaddr(b_emesh_srcaddr),
        .b_emesh_data(b_emesh_data), .b_emesh_wait(b_emesh_wait),
        .txo_emesh_access(txo_emesh_access), .txo_emesh_write(txo_emesh_write),
        .txo_emesh_datamode(txo_emesh_datamode), .txo_emesh_ctrlmode(txo_emesh_ctrlmode),
        .txo_emesh_dstaddr(txo_emesh_dstaddr), .txo_emesh_srcaddr(txo_emesh_srcaddr),
        .txo_emesh_data(txo_emesh_data), .txo_emesh_wait(txo_emesh_wait),
        .grant_a(grant_a), .grant_b(grant_b)
    );

    always #5 txo_lclk = ~txo_lclk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: who owns the port, how many in a row it has had, who wins the next tie.
    int          m_owner, m_run, m_pref;
    logic        m_acc, m_write;
    logic [1:0]  m_dm;
    logic [3:0]  m_cm;
    logic [31:0] m_dst, m_src, m_data;
    bit          a_hold, b_hold;
    int          accepted, delivered;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
`ifdef ETX_ARB_FIXED_PRIO_EN
        if (a_emesh_access) return 1;
        if (b_emesh_access) return 2;
        return 0;
`else
        if (m_owner == 1 && a_emesh_access && (m_run < MAXB || !b_emesh_access)) return 1;
        if (m_owner == 2 && b_emesh_access && (m_run < MAXB || !a_emesh_access)) return 2;
        if (a_emesh_access && b_emesh_access) return m_pref;
        if (a_emesh_access) return 1;
        if (b_emesh_access) return 2;
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_pref = 1;
        m_acc = 0; m_write = 0; m_dm = 0; m_cm = 0; m_dst = 0; m_src = 0; m_data = 0;
        a_hold = 0; b_hold = 0; accepted = 0; delivered = 0;
    endtask

    task automatic model_update();
        int s;
        bit ld;
        s  = pick();
        ld = !(m_acc && txo_emesh_wait);
        a_hold = a_emesh_access && !(ld && s == 1);
        b_hold = b_emesh_access && !(ld && s == 2);
        if (ld) begin
            if (s != 0) begin
                if (s == m_owner) m_run = (m_run == MAXB) ? 1 : m_run + 1;
                else begin m_owner = s; m_run = 1; m_pref = 3 - s; end
                m_acc = 1; accepted++;
                if (s == 1) begin
                    m_write = a_emesh_write; m_dm = a_emesh_datamode; m_cm = a_emesh_ctrlmode;
                    m_dst = a_emesh_dstaddr; m_src = a_emesh_srcaddr; m_data = a_emesh_data;
                end else begin
                    m_write = b_emesh_write; m_dm = b_emesh_datamode; m_cm = b_emesh_ctrlmode;
                    m_dst = b_emesh_dstaddr; m_src = b_emesh_srcaddr; m_data = b_emesh_data;
                end
            end else begin
                m_acc = 0; m_owner = 0; m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge txo_lclk);
        if (!reset) model_update();
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        a_emesh_access = 0; b_emesh_access = 0; txo_emesh_wait = 0;
        repeat (2) @(posedge txo_lclk);
        #3 reset = 1'b0;
    endtask

    always @(negedge txo_lclk) begin : compare
        int  s;
        bit  ld;
        if (chk_en && !reset) begin
            s  = pick();
            ld = !(m_acc && txo_emesh_wait);
            check("txo_access",   32'(txo_emesh_access),   32'(m_acc));
            check("txo_write",    32'(txo_emesh_write),    32'(m_write));
            check("txo_datamode", 32'(txo_emesh_datamode), 32'(m_dm));
            check("txo_ctrlmode", 32'(txo_emesh_ctrlmode), 32'(m_cm));
            check("txo_dstaddr",  txo_emesh_dstaddr, m_dst);
            check("txo_srcaddr",  txo_emesh_srcaddr, m_src);
            check("txo_data",     txo_emesh_data,    m_data);
            check("grant_a",      32'(grant_a), 32'(m_owner == 1));
            check("grant_b",      32'(grant_b), 32'(m_owner == 2));
            check("a_wait",       32'(a_emesh_wait), 32'(!(ld && s == 1)));
            check("b_wait",       32'(b_emesh_wait), 32'(!(ld && s == 2)));
            if (txo_emesh_access && !txo_emesh_wait) delivered++;
        end
    end

    int exp_ord[10];
    int exp_drop[8];

    initial begin
        model_reset();
        repeat (2) @(posedge txo_lclk);
        #3 reset = 1'b0;
        chk_en = 1'b1;
        check("rst_access", 32'(txo_emesh_access), 32'd0);
        check("rst_grant_a", 32'(grant_a), 32'd0);
        check("rst_grant_b", 32'(grant_b), 32'd0);

        // single A write
        a_emesh_access = 1; a_emesh_write = 1; a_emesh_datamode = 2'd2; a_emesh_ctrlmode = 4'd0;
        a_emesh_dstaddr = 32'h8080_0000; a_emesh_srcaddr = 32'h0000_0042; a_emesh_data = 32'h1234_5678;
        #1 check("single_a_wait", 32'(a_emesh_wait), 32'd0);
        tick();
        check("single_access", 32'(txo_emesh_access), 32'd1);
        check("single_dst", txo_emesh_dstaddr, 32'h8080_0000);
        check("single_data", txo_emesh_data, 32'h1234_5678);
        check("single_write", 32'(txo_emesh_write), 32'd1);
        a_emesh_access = 0;
        tick();
        check("single_gone", 32'(txo_emesh_access), 32'd0);

        // both continuous: bursts of MAXB alternate
        pulse_reset();
`ifdef ETX_ARB_FIXED_PRIO_EN
        exp_ord = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
        exp_drop = '{10, 10, 11, 10, 10, 10, 10, 10};
`else
        exp_ord = '{10, 10, 10, 10, 11, 11, 11, 11, 10, 10};
        exp_drop = '{10, 10, 11, 11, 11, 11, 10, 10};
`endif
        a_emesh_access = 1; a_emesh_data = 32'hA000_0000;
        b_emesh_access = 1; b_emesh_data = 32'hB000_0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("order_%0d", k), 32'(txo_emesh_data[31:28]), 32'(exp_ord[k]));
        end

        // A alone streams with no gap
        pulse_reset();
        a_emesh_access = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("a_stream_access", 32'(txo_emesh_access), 32'd1);
            check("a_stream_grant", 32'(grant_a), 32'd1);
        end

        // stall during a B burst
        pulse_reset();
        b_emesh_access = 1; b_emesh_data = 32'hB000_0000;
        repeat (2) begin
            tick();
            if (!b_hold) b_emesh_data = b_emesh_data + 1;
        end
        a_emesh_access = 1; txo_emesh_wait = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_a_wait", 32'(a_emesh_wait), 32'd1);
            check("stall_b_wait", 32'(b_emesh_wait), 32'd1);
            tick();
            check("stall_data", txo_emesh_data, 32'hB000_0001);
            check("stall_access", 32'(txo_emesh_access), 32'd1);
        end
        txo_emesh_wait = 0;
        repeat (12) begin
            tick();
            if (!b_hold) b_emesh_data = b_emesh_data + 1;
        end
        a_emesh_access = 0; b_emesh_access = 0;
        repeat (3) tick();
        check("stall_count_in_out", 32'(delivered), 32'(accepted));

        // A drops for one cycle mid-burst
        pulse_reset();
        a_emesh_access = 1; b_emesh_access = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("drop_%0d", k), 32'(txo_emesh_data[31:28]), 32'(exp_drop[k]));
            if (k == 1) a_emesh_access = 0;
            if (k == 2) a_emesh_access = 1;
        end

        // async reset mid-burst, then tie goes to A
        pulse_reset();
        a_emesh_access = 1; b_emesh_access = 1;
        repeat (3) tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("arst_access", 32'(txo_emesh_access), 32'd0);
        check("arst_grant_a", 32'(grant_a), 32'd0);
        check("arst_grant_b", 32'(grant_b), 32'd0);
        repeat (2) @(posedge txo_lclk);
        #3 reset = 1'b0;
        tick();
        check("arst_first_a", 32'(txo_emesh_data[31:28]), 32'hA);

        // randomized traffic with back-pressure
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            txo_emesh_wait = ($urandom_range(0, 3) == 0);
            if (!a_hold) begin
                a_emesh_access = ($urandom_range(0, 9) < 7);
                a_emesh_write = 1'($urandom); a_emesh_datamode = 2'($urandom);
                a_emesh_ctrlmode = 4'($urandom); a_emesh_dstaddr = $urandom;
                a_emesh_srcaddr = $urandom; a_emesh_data = $urandom;
            end
            if (!b_hold) begin
                b_emesh_access = ($urandom_range(0, 9) < 7);
                b_emesh_write = 1'($urandom); b_emesh_datamode = 2'($urandom);
                b_emesh_ctrlmode = 4'($urandom); b_emesh_dstaddr = $urandom;
                b_emesh_srcaddr = $urandom; b_emesh_data = $urandom;
            end
            tick();
        end
        a_emesh_access = 0; b_emesh_access = 0; txo_emesh_wait = 0;
        repeat (3) tick();
        check("rand_count_in_out", 32'(delivered), 32'(accepted));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
